// File: rtl/sram_like_resp_pkg.sv
// Shared memory-control definitions for the SRAM-like responder: bus widths,
// transfer-size encodings and the alignment rule applied to every request.
package sram_like_resp_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;
   localparam int LAT_W  = 4;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2,
      SIZE_RSVD = 2'd3
   } SizeE;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } RespStateE;

   // The reserved size is treated like a misaligned access.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
      logic bad;
      case (SizeE'(size))
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = addrLo[0];
         SIZE_WORD: bad = (addrLo != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order request queue of QDEPTH entries; the head entry is always visible
// on headData, and a push and a pop may happen in the same cycle.
module resp_fifo #(
   parameter int WIDTH  = 8,
   parameter int QDEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [WIDTH-1:0]          pushData,
   input  logic                      pop,
   output logic [WIDTH-1:0]          headData,
   output logic [$clog2(QDEPTH):0]   count
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);

   logic [WIDTH-1:0] store [QDEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= nextPtr(wrPtr);
         if (pop)  rdPtr <= nextPtr(rdPtr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) store[wrPtr] <= pushData;
   end

   assign headData = store[rdPtr];

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like responder: accepts up to QDEPTH requests, answers each in order a
// fixed LATENCY after it reaches the queue head, with write-lane strobes.
//
//   state | meaning
//   IDLE  | queue empty, nothing in flight
//   WAIT  | head entry counting down its latency
//   RESP  | head entry retires: data_ok pulse, memory write if any
module sram_like_resp
   import sram_like_resp_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int CNT_W = $clog2(QDEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
   localparam logic [LAT_W-1:0] LOAD_CNT = (LATENCY > 1) ? LAT_W'(LATENCY - 2) : '0;

   // Only what retirement needs is queued; alignment is judged at acceptance.
   typedef struct packed {
      logic              wr;
      logic              err;
      logic [ADDR_W-1:0] wordIdx;
      logic [STRB_W-1:0] wstrb;
      logic [DATA_W-1:0] wdata;
   } ReqEntry;

   ReqEntry          pushEntry;
   ReqEntry          headEntry;
   logic [CNT_W-1:0] count;
   logic             accept;
   logic             retire;
   logic             headLoad;
   logic             memWe;
   logic             unusedAddrHi;

   RespStateE        state;
   RespStateE        stateNext;
   logic [LAT_W-1:0] latCnt;
   logic [LAT_W-1:0] latCntNext;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   assign addr_ok = !rst && (count < FULL_CNT);
   assign accept  = req && addr_ok;
   assign retire  = !rst && (state == RESP);

   // Upper address bits alias onto the same words.
   assign unusedAddrHi = ^addr[31:ADDR_W+2];

   assign pushEntry.wr      = wr;
   assign pushEntry.err     = isMisaligned(size, addr[1:0]);
   assign pushEntry.wordIdx = addr[ADDR_W+1:2];
   assign pushEntry.wstrb   = wstrb;
   assign pushEntry.wdata   = wdata;

   resp_fifo #(
      .WIDTH  ($bits(ReqEntry)),
      .QDEPTH (QDEPTH)
   ) u_respFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (accept),
      .pushData (pushEntry),
      .pop      (retire),
      .headData (headEntry),
      .count    (count)
   );

   // A new head appears when an entry lands in an empty queue, or when the
   // retiring head leaves something (old or just accepted) behind it.
   assign headLoad = ((count == '0) && accept) ||
                     (retire && ((count > CNT_W'(1)) || accept));

   always_comb begin
      stateNext  = state;
      latCntNext = latCnt;
      if (headLoad) begin
         stateNext  = (LATENCY == 1) ? RESP : WAIT;
         latCntNext = LOAD_CNT;
      end else begin
         case (state)
            WAIT: begin
               if (latCnt == '0) stateNext  = RESP;
               else              latCntNext = latCnt - 1'b1;
            end
            RESP:    stateNext = IDLE;
            default: stateNext = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         latCnt <= '0;
      end else begin
         state  <= stateNext;
         latCnt <= latCntNext;
      end
   end

   assign memWe = retire && headEntry.wr && !headEntry.err;

   always_ff @(posedge clk) begin
      if (memWe) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (headEntry.wstrb[i]) mem[headEntry.wordIdx][i*8 +: 8] <= headEntry.wdata[i*8 +: 8];
         end
      end
   end

   assign data_ok = retire;
   assign err     = retire && headEntry.err;
   assign rdata   = (retire && !headEntry.wr && !headEntry.err) ? mem[headEntry.wordIdx] : '0;

endmodule

// File: tb/tb_sram_like_resp.sv
// Directed bench for sram_like_resp with default parameters (ADDR_W=10,
// LATENCY=2, QDEPTH=2); responses are logged with their cycle number.
module tb_sram_like_resp;

   localparam int LATENCY = 2;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic        err;
   } Resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        err;

   int  cyc = 0;
   int  nAsserts = 0;
   int  nFails = 0;
   Resp respQ[$];

   logic [31:0] pipeAddr [3] = '{32'h10, 32'h20, 32'h10};
   logic [31:0] pipeData [3] = '{32'hDEADBEEF, 32'h1122AA44, 32'hDEADBEEF};
   logic        pipeOkExp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   logic        pipeOkSeen [4];

   sram_like_resp #(
      .ADDR_W  (10),
      .LATENCY (LATENCY),
      .QDEPTH  (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wr      (wr),
      .size    (size),
      .addr    (addr),
      .wstrb   (wstrb),
      .wdata   (wdata),
      .addr_ok (addr_ok),
      .data_ok (data_ok),
      .rdata   (rdata),
      .err     (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      Resp r;
      if (data_ok === 1'b1) begin
         r.cyc   = cyc;
         r.rdata = rdata;
         r.err   = err;
         respQ.push_back(r);
      end else begin
         checkVal("idle_outputs_zero", rdata | {31'd0, err}, 32'd0);
      end
   end

   // Called #1 after a rising edge; returns #1 after the edge that accepted.
   task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] wd,
                        output int accCyc, output bit got);
      got    = 1'b0;
      accCyc = -1;
      req = 1'b1; wr = w; size = sz; addr = a; wstrb = st; wdata = wd;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (addr_ok === 1'b1) begin
            accCyc = cyc;
            got    = 1'b1;
         end
         @(posedge clk); #1;
      end
      req = 1'b0;
   endtask

   task automatic waitResp(output Resp r, output bit got);
      int n = 0;
      while (respQ.size() == 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      got = (respQ.size() != 0);
      if (got) r = respQ.pop_front();
      else begin
         r.cyc = -1; r.rdata = '0; r.err = 1'b0;
      end
   endtask

   task automatic transact(input string tag, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd,
                           input logic [31:0] expRd, input logic expErr);
      int  accCyc;
      bit  got;
      Resp r;
      issue(w, sz, a, st, wd, accCyc, got);
      checkVal({tag, "_accepted"}, 32'(got), 32'd1);
      if (!got) return;
      waitResp(r, got);
      checkVal({tag, "_responded"}, 32'(got), 32'd1);
      if (!got) return;
      checkVal({tag, "_latency"}, 32'(r.cyc - accCyc), 32'(LATENCY));
      checkVal({tag, "_rdata"}, r.rdata, expRd);
      checkVal({tag, "_err"}, 32'(r.err), 32'(expErr));
      @(negedge clk);
      checkVal({tag, "_single_pulse"}, 32'(data_ok), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  acc [3];
      int  nIss;
      int  accCyc;
      bit  got;
      Resp r;

      rst = 1'b1; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10; wstrb = 4'hF; wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkVal("rst_addr_ok", 32'(addr_ok), 32'd0);
      checkVal("rst_data_ok", 32'(data_ok), 32'd0);
      checkVal("rst_rdata", rdata, 32'd0);
      checkVal("rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      @(negedge clk);
      checkVal("addr_ok_after_rst", 32'(addr_ok), 32'd1);
      @(posedge clk); #1;
      checkVal("no_resp_from_rst_req", 32'(respQ.size()), 32'd0);

      transact("wr10", 1'b1, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
      transact("rd10", 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);

      transact("pre20", 1'b1, 2'd2, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0);
      transact("wrb21", 1'b1, 2'd0, 32'h21, 4'b0010, 32'h0000AA00, 32'h0, 1'b0);
      transact("rd20", 1'b0, 2'd2, 32'h20, 4'h0, 32'h0, 32'h1122AA44, 1'b0);

      nIss = 0;
      for (int att = 0; att < 20 && nIss < 3; att++) begin
         req = 1'b1; wr = 1'b0; size = 2'd2; addr = pipeAddr[nIss]; wstrb = 4'h0; wdata = '0;
         @(negedge clk);
         if (att < 4) pipeOkSeen[att] = addr_ok;
         if (addr_ok === 1'b1) begin
            acc[nIss] = cyc;
            nIss++;
         end
         @(posedge clk); #1;
      end
      req = 1'b0;
      checkVal("pipe_issued", 32'(nIss), 32'd3);
      for (int k = 0; k < 4; k++) checkVal($sformatf("pipe_addr_ok%0d", k), 32'(pipeOkSeen[k]), 32'(pipeOkExp[k]));
      for (int k = 0; k < 3; k++) begin
         waitResp(r, got);
         checkVal($sformatf("pipe_resp%0d_seen", k), 32'(got), 32'd1);
         checkVal($sformatf("pipe_resp%0d_cycle", k), 32'(r.cyc - acc[0]), 32'(LATENCY * (k + 1)));
         checkVal($sformatf("pipe_resp%0d_rdata", k), r.rdata, pipeData[k]);
      end
      repeat (3) @(posedge clk); #1;
      checkVal("pipe_no_extra_resp", 32'(respQ.size()), 32'd0);

      transact("wrh22", 1'b1, 2'd1, 32'h22, 4'b1100, 32'hBEEF0000, 32'h0, 1'b0);
      transact("rdh22", 1'b0, 2'd1, 32'h22, 4'h0, 32'h0, 32'hBEEFAA44, 1'b0);

      transact("pre04", 1'b1, 2'd2, 32'h04, 4'hF, 32'h0BADF00D, 32'h0, 1'b0);
      transact("wr06_mis", 1'b1, 2'd2, 32'h06, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1);
      transact("rd04", 1'b0, 2'd2, 32'h04, 4'h0, 32'h0, 32'h0BADF00D, 1'b0);
      transact("rdh05_mis", 1'b0, 2'd1, 32'h05, 4'h0, 32'h0, 32'h0, 1'b1);
      transact("rd04_rsvd", 1'b0, 2'd3, 32'h04, 4'h0, 32'h0, 32'h0, 1'b1);
      transact("rdh06", 1'b0, 2'd1, 32'h06, 4'h0, 32'h0, 32'h0BADF00D, 1'b0);
      transact("rdb07", 1'b0, 2'd0, 32'h07, 4'h0, 32'h0, 32'h0BADF00D, 1'b0);

      transact("pre30", 1'b1, 2'd2, 32'h30, 4'hF, 32'h30303030, 32'h0, 1'b0);
      issue(1'b1, 2'd2, 32'h30, 4'hF, 32'h12345678, accCyc, got);
      checkVal("wr30_accepted", 32'(got), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkVal("midrst_addr_ok", 32'(addr_ok), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkVal("addr_ok_after_midrst", 32'(addr_ok), 32'd1);
      repeat (4) @(posedge clk); #1;
      checkVal("midrst_no_resp", 32'(respQ.size()), 32'd0);
      transact("rd30_after_rst", 1'b0, 2'd2, 32'h30, 4'h0, 32'h0, 32'h30303030, 1'b0);

      transact("wr000", 1'b1, 2'd2, 32'h0000_0000, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0);
      transact("wr1000", 1'b1, 2'd2, 32'h0000_1000, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0);
      transact("rd000_alias", 1'b0, 2'd2, 32'h0000_0000, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/sram_like_resp.md
SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to data_ok; legal range 1..15.
REQ-003 Parameter QDEPTH, default 2, number of outstanding requests; power of two.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  1  initiator request valid.
REQ-007 wr  input  1  1 = write, 0 = read.
REQ-008 size  input  2  transfer size: 0 = byte, 1 = half, 2 = word; 3 is reserved and flagged as an error.
REQ-009 addr  input  32  byte address.
REQ-010 wstrb  input  4  write byte-lane enables.
REQ-011 wdata  input  32  write data.
REQ-012 addr_ok  output  1  request accepted this cycle when req is also high.
REQ-013 data_ok  output  1  one-cycle response pulse.
REQ-014 rdata  output  32  read data, valid with data_ok.
REQ-015 err  output  1  misalignment/size error, valid with data_ok.

Function
REQ-016 A request SHALL be accepted exactly in a cycle where req=1 and addr_ok=1; wr, size, addr, wstrb and wdata are captured in that cycle.
REQ-017 addr_ok SHALL be 1 iff the outstanding count is below QDEPTH at the start of the cycle; retirement in the same cycle SHALL NOT raise addr_ok early.
REQ-018 Accepted requests SHALL be held in an in-order FIFO of QDEPTH entries, with wrap-around pointers and a count in the range 0..QDEPTH.
REQ-019 The head entry SHALL use a latency counter with states IDLE, WAIT and RESP.
  - IDLE -> WAIT when the FIFO is non-empty.
  - The counter loads when the entry becomes head.
  - data_ok SHALL assert exactly LATENCY cycles after acceptance for an entry that reaches an empty FIFO head.
  - For queued entries, data_ok SHALL assert no sooner than 1 cycle after the previous entry's data_ok.
REQ-020 data_ok SHALL pulse for exactly one cycle per accepted request; requests retire strictly in acceptance order.
REQ-021 The word index SHALL be addr[ADDR_W+1:2]; addr[31:ADDR_W+2] SHALL be ignored, so the address space aliases.
REQ-022 err=1 SHALL be raised for size=3, for size=1 with addr[0]=1, and for size=2 with addr[1:0]!=0.
REQ-023 A write with err=0 SHALL update only the lanes with wstrb[i]=1, in the data_ok cycle. A write with err=1 SHALL NOT modify memory.
REQ-024 A read SHALL return the full stored word on rdata; byte/half extraction is the initiator's job. A read SHALL reflect every write whose data_ok occurred in an earlier cycle.
REQ-025 On a write response, and on any err response, rdata SHALL be 0.
REQ-026 Acceptance and retirement in the same cycle SHALL leave the count unchanged; simultaneous pointer updates SHALL be exact.
REQ-027 When data_ok=0, rdata and err SHALL hold 0.

Reset
REQ-028 While rst=1:
  - addr_ok=0, data_ok=0, rdata=0, err=0.
  - FIFO pointers and count are 0; the state machine is IDLE.
  - Any request presented is not accepted.
REQ-029 Reset mid-operation SHALL discard all outstanding requests with no data_ok. Writes not yet retired SHALL NOT reach memory.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 addr_ok SHALL return to 1 in the first cycle after rst deasserts.

Structure
REQ-032 The size encodings (BYTE/HALF/WORD) and the misalignment check SHALL live in the shared defines package alongside the existing memory-control constants.
REQ-033 One sub-module is natural: resp_fifo, a parameterised QDEPTH-entry request queue. The memory array and latency control stay in sram_like_resp.

Verification
REQ-034 Reset, then write word addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, then read 0x10 -> data_ok 2 cycles after each acceptance; read rdata=0xDEADBEEF, err=0.
REQ-035 Preload 0x11223344 at 0x20; write addr 0x21, size=0, wstrb 4'b0010, wdata 0x0000AA00; read 0x20 -> rdata=0x1122AA44.
REQ-036 Three back-to-back reads with QDEPTH=2 -> addr_ok=0 during the third request's first cycle; three in-order data_ok pulses; count never exceeds 2.
REQ-037 Write addr 0x06, size=2, wdata 0xFFFFFFFF -> err=1, rdata=0; a subsequent read of 0x04 returns its unchanged value.
REQ-038 Accept a write to 0x30, then assert rst in the next cycle -> no data_ok; read of 0x30 after reset returns its pre-write value.
REQ-039 Write addr 0x0000_1000 and 0x0000_0000 with ADDR_W=10 -> the two addresses alias; a read of 0x0 returns the last written data.
